simon_param_core: RTL and testbench

Parametrised iterative SIMON encryption core that generalises the fixed-key Simon32/64 bit-serial block to any SIMON 2N/(M·N) variant with a run-time loaded key. Key and plaintext are loaded serially over the `data_in`/`data_rdy` interface. The core then computes one round per cycle and shifts the ciphertext out serially with `valid`. It sits at the top of the cipher datapath, and a debug mux exposes the key path on the output pin.

---
 rtl/simon_param_core.sv | 124 ++++++++++++
 tb/tb_simon_param_core.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_param_core.sv
// rtl/simon_param_core.sv - Iterative SIMON 2N/(M*N) core with serial key/plaintext load and serial ciphertext out.
// Optional SIMON_KEY_RESTORE_EN keeps a shadow of the loaded key and restores it after each run.
module simon_param_core #(
    parameter int          N = 16,
    parameter int          M = 4,
    parameter int          T = 32,
    parameter logic [61:0] Z = 62'b0110011100001101010010001011111_0110011100001101010010001011111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
    input  logic [1:0] data_rdy,
    input  logic       debug_port,
    output logic       cipher_out,
    output logic       valid,
    output logic       busy
);

    localparam int KW  = M * N;
    localparam int BW  = 2 * N;
    localparam int RCW = (T > 1) ? $clog2(T) : 1;
    localparam int OCW = $clog2(BW);

    typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

    state_t         state;
    logic [KW-1:0]  kr;
    logic [BW-1:0]  br;
    logic [RCW-1:0] rc;
    logic [5:0]     zi;
    logic [OCW-1:0] oc;
`ifdef SIMON_KEY_RESTORE_EN
    logic [KW-1:0]  shadow;
`endif

    logic [N-1:0] x, y, k0, k1, kt, fx, tmp, new_key;

    function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int s);
        return (v << s) | (v >> (N - s));
    endfunction

    function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int s);
        return (v >> s) | (v << (N - s));
    endfunction

    assign x  = br[BW-1:N];
    assign y  = br[N-1:0];
    assign k0 = kr[N-1:0];
    assign k1 = kr[2*N-1:N];
    assign kt = kr[KW-1:KW-N];

    // Round function and next key word; z constant only touches bit 0.
    always_comb begin
        fx  = (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);
        tmp = ror(kt, 3);
        if (M == 4) tmp = tmp ^ k1;
        tmp     = tmp ^ ror(tmp, 1);
        new_key = ~k0 ^ tmp ^ {{(N-1){1'b0}}, Z[zi]} ^ N'(3);
    end

    assign cipher_out = debug_port ? kr[0] : br[BW-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            kr     <= '0;
            br     <= '0;
            rc     <= '0;
            zi     <= '0;
            oc     <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
`ifdef SIMON_KEY_RESTORE_EN
            shadow <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    case (data_rdy)
                        2'b01: begin
                            kr     <= {kr[KW-2:0], data_in};
`ifdef SIMON_KEY_RESTORE_EN
                            shadow <= {shadow[KW-2:0], data_in};
`endif
                        end
                        2'b10: br <= {br[BW-2:0], data_in};
                        2'b11: begin
                            state <= RUN;
                            busy  <= 1'b1;
                            rc    <= '0;
                            zi    <= '0;
                        end
                        default: ;
                    endcase
                end
                RUN: begin
                    br <= {y ^ fx ^ k0, x};
                    kr <= {new_key, kr[KW-1:N]};
                    rc <= rc + RCW'(1);
                    zi <= (zi == 6'd61) ? 6'd0 : zi + 6'd1;
                    if (rc == RCW'(T - 1)) begin
                        state <= OUT;
                        valid <= 1'b1;
                        oc    <= '0;
                    end
                end
                OUT: begin
                    br <= {br[BW-2:0], 1'b0};
                    oc <= oc + OCW'(1);
                    if (oc == OCW'(BW - 1)) begin
                        state <= IDLE;
                        valid <= 1'b0;
                        busy  <= 1'b0;
`ifdef SIMON_KEY_RESTORE_EN
                        kr    <= shadow;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_param_core.sv
// tb/tb_simon_param_core.sv - Randomised self-checking bench for simon_param_core (Simon32/64 defaults).
module tb_simon_param_core;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       data_in = 1'b0;
    logic [1:0] data_rdy = 2'b00;
    logic       debug_port = 1'b0;
    logic       cipher_out, valid, busy;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] KEY0 = 64'h1918111009080100;
    localparam logic [31:0] PT0  = 32'h65656877;
    localparam logic [31:0] CT0  = 32'hC69BE9BB;

    string zs = "11111010001001010110000111001101111101000100101011000011100110";
    logic [15:0] rk [0:35];

    simon_param_core dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_rdy   (data_rdy),
        .debug_port (debug_port),
        .cipher_out (cipher_out),
        .valid      (valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rol16(input logic [15:0] v, input int s);
        return (v << s) | (v >> (16 - s));
    endfunction

    function automatic logic [15:0] ror16(input logic [15:0] v, input int s);
        return (v >> s) | (v << (16 - s));
    endfunction

    // Textbook Simon32/64: expand all round keys, then run the Feistel rounds.
    task automatic model_run(input logic [63:0] key, input logic [31:0] pt, output logic [31:0] ct);
        logic [15:0] x, y, t, tmp;
        for (int i = 0; i < 4; i++) rk[i] = key[16*i +: 16];
        for (int i = 4; i < 36; i++) begin
            tmp = ror16(rk[i-1], 3) ^ rk[i-3];
            tmp = tmp ^ ror16(tmp, 1);
            rk[i] = ~rk[i-4] ^ tmp ^ {15'd0, (zs[(i-4) % 62] == 8'h31)} ^ 16'd3;
        end
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            t = x;
            x = y ^ ((rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2)) ^ rk[i];
            y = t;
        end
        ct = {x, y};
    endtask

    function automatic logic [63:0] final_key(input logic [63:0] key);
`ifdef SIMON_KEY_RESTORE_EN
        return key;
`else
        return {rk[35], rk[34], rk[33], rk[32]};
`endif
    endfunction

    task automatic load_key(input logic [63:0] k);
        for (int i = 63; i >= 0; i--) begin
            data_rdy = 2'b01; data_in = k[i];
            @(posedge clk); #1;
        end
        data_rdy = 2'b00; data_in = 1'b0;
    endtask

    task automatic load_pt(input logic [31:0] p);
        for (int i = 31; i >= 0; i--) begin
            data_rdy = 2'b10; data_in = p[i];
            @(posedge clk); #1;
        end
        data_rdy = 2'b00; data_in = 1'b0;
    endtask

    task automatic start_run();
        data_rdy = 2'b11;
        @(posedge clk); #1;
        data_rdy = 2'b00;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL start_busy: busy=%b required 1", busy);
        end
    endtask

    // Waits for valid and shifts in 32 bits; returns at the first IDLE cycle.
    task automatic collect(input bit noisy, input bit check_lat, output logic [31:0] ct);
        int lat = 0;
        int vcnt = 0;
        while (valid !== 1'b1 && lat < 200) begin
            if (noisy) begin data_rdy = 2'($urandom); data_in = 1'($urandom); end
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat >= 200) begin
            errors++; $display("FAIL valid_timeout: no valid within %0d cycles", lat);
        end else if (check_lat && lat != 32) begin
            errors++; $display("FAIL latency: got %0d cycles required 32", lat);
        end
        for (int b = 31; b >= 0; b--) begin
            ct[b] = cipher_out;
            if (valid === 1'b1) vcnt++;
            if (noisy) begin data_rdy = 2'($urandom); data_in = 1'($urandom); end
            @(posedge clk); #1;
        end
        data_rdy = 2'b00; data_in = 1'b0;
        checks++;
        if (vcnt != 32) begin
            errors++; $display("FAIL valid_width: high %0d cycles required 32", vcnt);
        end
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL end_idle: valid=%b busy=%b required 0 0", valid, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || cipher_out !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: busy=%b valid=%b cipher_out=%b required 0 0 0", busy, valid, cipher_out);
        end
        checks++;
        if (dut.kr !== 64'd0 || dut.br !== 32'd0) begin
            errors++; $display("FAIL reset_regs: kr=%h br=%h required 0 0", dut.kr, dut.br);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_default_vector();
        logic [31:0] ct, exp_ct;
        model_run(KEY0, PT0, exp_ct);
        checks++;
        if (exp_ct !== CT0) begin
            errors++; $display("FAIL model_vector: model=%h required %h", exp_ct, CT0);
        end
        load_key(KEY0);
        debug_port = 1'b1; #1;
        checks++;
        if (cipher_out !== 1'b0) begin
            errors++; $display("FAIL debug_idle_default: cipher_out=%b required 0", cipher_out);
        end
        debug_port = 1'b0;
        load_pt(PT0);
        start_run();
        collect(1'b0, 1'b1, ct);
        checks++;
        if (ct !== CT0) begin
            errors++; $display("FAIL default_ct: got %h required %h", ct, CT0);
        end
        checks++;
        if (dut.kr !== final_key(KEY0)) begin
            errors++; $display("FAIL post_run_kr: got %h required %h", dut.kr, final_key(KEY0));
        end
    endtask

    task automatic test_key_restore();
        logic [31:0] ct, exp_ct;
        logic [63:0] k;
        model_run(KEY0, PT0, exp_ct);
        k = final_key(KEY0);
        model_run(k, PT0, exp_ct);
        load_pt(PT0);
        start_run();
        collect(1'b0, 1'b1, ct);
        checks++;
        if (ct !== exp_ct) begin
            errors++; $display("FAIL restore_ct: got %h required %h", ct, exp_ct);
        end
`ifndef SIMON_KEY_RESTORE_EN
        checks++;
        if (ct === CT0 || k === KEY0) begin
            errors++; $display("FAIL norestore_differs: ct=%h key=%h must differ from %h %h", ct, k, CT0, KEY0);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] ct, exp_ct;
        logic [63:0] key, k;
        logic [31:0] pt;
        key = {$urandom, $urandom};
        pt  = $urandom;
        load_key(key);
        load_pt(pt);
        model_run(key, pt, exp_ct);
        k = final_key(key);
        start_run();
        collect(1'b0, 1'b1, ct);
        checks++;
        if (ct !== exp_ct) begin
            errors++; $display("FAIL b2b_first: got %h required %h", ct, exp_ct);
        end
        // Start in the first IDLE cycle: block register has shifted out to zero.
        model_run(k, 32'd0, exp_ct);
        start_run();
        collect(1'b0, 1'b1, ct);
        checks++;
        if (ct !== exp_ct) begin
            errors++; $display("FAIL b2b_second: got %h required %h", ct, exp_ct);
        end
    endtask

    task automatic test_debug();
        logic [31:0] ct, exp_ct;
        logic [63:0] key;
        logic [31:0] pt;
        int bad = 0;
        key = {$urandom, $urandom} | 64'd1;
        pt  = $urandom;
        load_key(key);
        load_pt(pt);
        model_run(key, pt, exp_ct);
        debug_port = 1'b1; #1;
        checks++;
        if (cipher_out !== 1'b1) begin
            errors++; $display("FAIL debug_idle: cipher_out=%b required 1", cipher_out);
        end
        start_run();
        for (int i = 0; i < 32; i++) begin
            if (cipher_out !== rk[i][0] || valid !== 1'b0) bad++;
            if (i < 31) begin @(posedge clk); #1; end
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL debug_run: %0d cycles where cipher_out differed from k0 bit or valid set, required 0", bad);
        end
        @(posedge clk); #1;
        checks++;
        if (valid !== 1'b1) begin
            errors++; $display("FAIL debug_valid: valid=%b required 1", valid);
        end
        debug_port = 1'b0; #1;
        collect(1'b0, 1'b0, ct);
        checks++;
        if (ct !== exp_ct) begin
            errors++; $display("FAIL debug_ct: got %h required %h", ct, exp_ct);
        end
    endtask

    task automatic test_busy_commands();
        logic [31:0] ct, exp_ct;
        logic [63:0] key;
        logic [31:0] pt;
        for (int r = 0; r < 3; r++) begin
            key = (r == 0) ? KEY0 : {$urandom, $urandom};
            pt  = (r == 0) ? PT0 : $urandom;
            load_key(key);
            load_pt(pt);
            model_run(key, pt, exp_ct);
            start_run();
            collect(1'b1, 1'b1, ct);
            checks++;
            if (ct !== exp_ct) begin
                errors++; $display("FAIL busy_cmd_ct[%0d]: got %h required %h", r, ct, exp_ct);
            end
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if (busy !== 1'b0 || valid !== 1'b0) begin
                errors++; $display("FAIL busy_cmd_restart[%0d]: busy=%b valid=%b required 0 0", r, busy, valid);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] ct;
        load_key(KEY0);
        load_pt(PT0);
        start_run();
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0; #1;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || cipher_out !== 1'b0) begin
            errors++; $display("FAIL midrun_outputs: busy=%b valid=%b cipher_out=%b required 0 0 0", busy, valid, cipher_out);
        end
        checks++;
        if (dut.kr !== 64'd0 || dut.br !== 32'd0) begin
            errors++; $display("FAIL midrun_regs: kr=%h br=%h required 0 0", dut.kr, dut.br);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrun_no_valid: valid=%b busy=%b required 0 0", valid, busy);
        end
        load_key(KEY0);
        load_pt(PT0);
        start_run();
        collect(1'b0, 1'b1, ct);
        checks++;
        if (ct !== CT0) begin
            errors++; $display("FAIL midrun_reload_ct: got %h required %h", ct, CT0);
        end
    endtask

    initial begin
        test_reset();
        test_default_vector();
        test_key_restore();
        test_back_to_back();
        test_debug();
        test_busy_commands();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
